abofs_point_walker: RTL
=======================

# abofs_point_walker

Receiving end of the accumulation-block offset (abofs) handshake produced by the accumulation block looper, one instance per i0/i1/o stream. It accepts one packet per accumulation block: block offset, per-dimension accumulation window `[aofs_beg, aofs_end)` and config-id range `[beg, end)`. It expands the packet into a stream of points, one per (config id, window coordinate), on a registered rdy/ack output. It sits between the block looper and the address generators of the TileAccumUnit.

## Interface
- `BW`, `TauCfg::WORK_BW`: offset width
- `DIM`, `TauCfg::VDIM`: number of dimensions
- `IDBW`, `$clog2(TauCfg::N_ICFG+1)`: config-id width
- `i_clk`  in  1  clock
- `i_rst`  in  1  one clock; reset is synchronous and active-low
- `abofs_rdy`  in  1  packet valid
- `abofs_ack`  out  1  packet accepted (combinational)
- `i_bofs`  in  BW×DIM  block offset
- `i_aofs_beg`  in  BW×DIM  window begin
- `i_aofs_end`  in  BW×DIM  window end (exclusive)
- `i_beg`  in  IDBW  first config id
- `i_end`  in  IDBW  config id end (exclusive)
- `pt_rdy`  out  1  point valid (registered)
- `pt_ack`  in  1  point consumed
- `o_bofs`  out  BW×DIM  block offset of the current packet
- `o_aofs`  out  BW×DIM  current window coordinate
- `o_id`  out  IDBW  current config id
- `o_islast`  out  1  current point is the packet's last
- `done_dval`  out  1  only with `ABW_DONE_EN`

## Operation
- States: IDLE, BUSY. Reset state is IDLE.
- Reset values: `pt_rdy`=0, every data output 0, `o_islast`=0.
- Accept: `abofs_ack = abofs_rdy && (IDLE || (pt_ack && o_islast))`.
- On accept:
  - latch `i_bofs`, `i_aofs_beg`, `i_aofs_end`, `i_end`.
  - load `o_aofs`=`i_aofs_beg`, `o_id`=`i_beg`.
  - enter or stay in BUSY, with `pt_rdy`=1 the next cycle.
- Iteration order:
  - config id is outermost.
  - within an id, dimension DIM-1 is innermost and dimension 0 is outermost.
- Advance on `pt_ack` when not last:
  - increment `o_aofs[DIM-1]`.
  - if the incremented value equals `aofs_end[d]`, wrap dimension d to `aofs_beg[d]` and carry to d-1.
  - a carry out of dimension 0 wraps all dimensions and increments `o_id`.
- `o_islast` is combinational from registered state: every `o_aofs[d]+1 == aofs_end[d]` and `o_id+1 == end`.
- On `pt_ack` with `o_islast`:
  - with no new packet accepted that cycle, go IDLE and drop `pt_rdy` the next cycle.
  - with a new packet accepted that cycle, load it directly (zero-bubble).
- Preconditions, guaranteed upstream: `beg < end` and `aofs_beg[d] < aofs_end[d]`. Behaviour is undefined otherwise.
- Comparisons use BW-bit unsigned arithmetic. The `+1` terms are computed at BW+1 bits so that `aofs_end`=2^BW-1 cannot alias.
- Outputs hold while `pt_rdy && !pt_ack`.
- Reset asserted mid-packet: the packet is abandoned, the block returns to IDLE, and all outputs go to their reset values on that edge.

## Timing
- Latency from `abofs_ack` to first `pt_rdy`: 1 cycle.
- Throughput: 1 point per cycle while `pt_ack` is held high, including across packet boundaries.
- Points per packet: (end−beg)·Π(aofs_end[d]−aofs_beg[d]).
- `abofs_ack` never asserts while BUSY unless the last point is acked in the same cycle.

## Configuration
- `ABW_DONE_EN` defined:
  - `done_dval` port exists.
  - It pulses for 1 cycle in the cycle `pt_ack && o_islast`.
  - Its reset value is 0.
- `ABW_DONE_EN` not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package (TauCfg): `WORK_BW`, `VDIM`, `N_ICFG`. Add a `typedef enum logic {ABW_IDLE, ABW_BUSY}` there.
- One natural sub-module is `nd_wrap_counter`. It holds the DIM-dimension counter with begin/end bounds, an increment input, and wrap/carry-out outputs. The id counter is a separate scalar.

## Test plan
- DIM=2, beg=0, end=1, aofs_beg={0,0}, aofs_end={2,3}, `pt_ack` held 1 -> 6 points (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; `o_islast` only on (1,2).
- beg=2, end=4, window {5..6}×{7..7} -> points in order (id,a0,a1) = (2,5,7)(2,6,7)(3,5,7)(3,6,7).
- Two back-to-back packets, each with a single point, `abofs_rdy` held -> second `abofs_ack` in the same cycle as the first last `pt_ack`; `pt_rdy` never drops.
- `pt_ack` random 30% duty -> outputs stable while stalled; the point sequence matches a golden model.
- Reset asserted at the 3rd point of a 6-point packet -> `pt_rdy`=0 and outputs 0 the next cycle; a following packet starts from its `aofs_beg`.
- With `ABW_DONE_EN`: 3 packets -> exactly 3 `done_dval` pulses, each coincident with a last-point ack.

Source files
------------

// File: rtl/abofs_point_walker_pkg.sv
// rtl/abofs_point_walker_pkg.sv - shared TileAccumUnit configuration and walker state type
package TauCfg;

   localparam int WORK_BW = 4;
   localparam int VDIM    = 2;
   localparam int N_ICFG  = 6;

   typedef enum logic {
      ABW_IDLE,
      ABW_BUSY
   } abw_state_e;

endpackage

// File: rtl/abofs_point_walker_nd_wrap_counter.sv
// rtl/abofs_point_walker_nd_wrap_counter.sv - DIM-dimension window counter with per-dimension begin/end wrap
module nd_wrap_counter
   import TauCfg::*;
#(
   parameter int BW  = WORK_BW,
   parameter int DIM = VDIM
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [BW*DIM-1:0] beg_i,
   input  logic [BW*DIM-1:0] end_i,
   input  logic              inc_i,
   output logic [BW*DIM-1:0] cnt_o,
   output logic              last_o,
   output logic              wrap_o
);

   logic [BW*DIM-1:0] cnt_q, cnt_d;
   logic [BW*DIM-1:0] beg_q, beg_d;
   logic [BW*DIM-1:0] end_q, end_d;
   logic [BW*DIM-1:0] step;
   logic [DIM-1:0]    at_end;

   // Dimension DIM-1 is innermost. A dimension steps only when every inner
   // dimension sits on its final coordinate; it wraps to its begin bound when
   // its own +1 reaches the end bound. The +1 is one bit wider so an end bound
   // of all-ones cannot alias.
   for (genvar g = 0; g < DIM; g++) begin : g_dim
      logic [BW:0] nxt;
      logic        cin;

      assign nxt        = {1'b0, cnt_q[g*BW +: BW]} + (BW+1)'(1);
      assign at_end[g]  = (nxt == {1'b0, end_q[g*BW +: BW]});

      if (g == DIM-1) begin : g_inner
         assign cin = 1'b1;
      end else begin : g_outer
         assign cin = &at_end[DIM-1:g+1];
      end

      assign step[g*BW +: BW] = !cin      ? cnt_q[g*BW +: BW] :
                                at_end[g] ? beg_q[g*BW +: BW] :
                                            nxt[BW-1:0];
   end

   assign last_o = &at_end;
   assign wrap_o = inc_i && last_o;
   assign cnt_o  = cnt_q;

   // Next-state: a load replaces bounds and restarts at begin, otherwise step on increment.
   always_comb begin
      cnt_d = cnt_q;
      beg_d = beg_q;
      end_d = end_q;
      if (load_i) begin
         cnt_d = beg_i;
         beg_d = beg_i;
         end_d = end_i;
      end else if (inc_i) begin
         cnt_d = step;
      end
   end

   // Counter and bound registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         beg_q <= '0;
         end_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         beg_q <= beg_d;
         end_q <= end_d;
      end
   end

endmodule

// File: rtl/abofs_point_walker.sv
// rtl/abofs_point_walker.sv - expands abofs packets into (id, window) point stream; ABW_DONE_EN adds done_dval
module abofs_point_walker
   import TauCfg::*;
#(
   parameter int BW   = WORK_BW,
   parameter int DIM  = VDIM,
   parameter int IDBW = $clog2(N_ICFG + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              abofs_rdy,
   output logic              abofs_ack,
   input  logic [BW*DIM-1:0] i_bofs,
   input  logic [BW*DIM-1:0] i_aofs_beg,
   input  logic [BW*DIM-1:0] i_aofs_end,
   input  logic [IDBW-1:0]   i_beg,
   input  logic [IDBW-1:0]   i_end,
   output logic              pt_rdy,
   input  logic              pt_ack,
   output logic [BW*DIM-1:0] o_bofs,
   output logic [BW*DIM-1:0] o_aofs,
   output logic [IDBW-1:0]   o_id,
   output logic              o_islast
`ifdef ABW_DONE_EN
   ,
   output logic              done_dval
`endif
);

   abw_state_e        state_q, state_d;
   logic [BW*DIM-1:0] bofs_q, bofs_d;
   logic [IDBW-1:0]   id_q, id_d;
   logic [IDBW-1:0]   idend_q, idend_d;
   logic [IDBW:0]     id_inc;
   logic              busy;
   logic              win_last;
   logic              win_wrap;
   logic              id_last;
   logic              fire;
   logic              last_fire;
   logic              adv;

   assign busy      = (state_q == ABW_BUSY);
   assign id_inc    = {1'b0, id_q} + (IDBW+1)'(1);
   assign id_last   = (id_inc == {1'b0, idend_q});
   assign o_islast  = busy && win_last && id_last;
   assign fire      = busy && pt_ack;
   assign last_fire = fire && o_islast;
   assign adv       = fire && !o_islast;

   // A new packet is taken when idle or when the last point leaves this cycle.
   assign abofs_ack = abofs_rdy && (!busy || last_fire);

   assign pt_rdy = busy;
   assign o_bofs = bofs_q;
   assign o_id   = id_q;

`ifdef ABW_DONE_EN
   assign done_dval = last_fire;
`endif

   nd_wrap_counter #(
      .BW  (BW),
      .DIM (DIM)
   ) u_win (
      .clk_i  (i_clk),
      .rst_ni (i_rst),
      .load_i (abofs_ack),
      .beg_i  (i_aofs_beg),
      .end_i  (i_aofs_end),
      .inc_i  (adv),
      .cnt_o  (o_aofs),
      .last_o (win_last),
      .wrap_o (win_wrap)
   );

   // Next-state: load on accept, step the id when the window wraps, go idle after the last point.
   always_comb begin
      state_d = state_q;
      bofs_d  = bofs_q;
      id_d    = id_q;
      idend_d = idend_q;
      if (abofs_ack) begin
         state_d = ABW_BUSY;
         bofs_d  = i_bofs;
         id_d    = i_beg;
         idend_d = i_end;
      end else begin
         if (last_fire) begin
            state_d = ABW_IDLE;
         end
         if (win_wrap) begin
            id_d = id_inc[IDBW-1:0];
         end
      end
   end

   // State and packet registers; reset abandons any packet in flight.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ABW_IDLE;
         bofs_q  <= '0;
         id_q    <= '0;
         idend_q <= '0;
      end else begin
         state_q <= state_d;
         bofs_q  <= bofs_d;
         id_q    <= id_d;
         idend_q <= idend_d;
      end
   end

endmodule
